counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arb_pkg.sv | 18 +
 rtl/load_counter.sv | 25 ++
 rtl/counter_arbiter.sv | 98 +++++++++
 tb/tb_counter_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_arb_pkg.sv
// Shared types and constants for the counter arbiter slice.
`timescale 1ns/1ps
package counter_arb_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Round-robin pick between two requesters: ptr names the favoured one.
  function automatic logic pick(input logic [1:0] req, input logic ptr);
    return req[ptr] ? ptr : ~ptr;
  endfunction

endpackage

// File: rtl/load_counter.sv
// Shared interval counter: synchronous clear-to-zero and increment enable.
`timescale 1ns/1ps
module load_counter
  import counter_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter granting a shared counter for len+1 cycles.
`timescale 1ns/1ps
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       done
);

  state_t           state, state_d;
  logic             ptr, ptr_d;
  logic [WIDTH-1:0] len_lat, len_d;
  logic [1:0]       gnt_d, done_d;
  logic             clr, en;
  logic             owner, win;

  // gnt is one-hot while in RUN, so its upper bit names the owner.
  assign owner = gnt[1];
  assign win   = pick(req, ptr);

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    len_d   = len_lat;
    gnt_d   = '0;
    done_d  = '0;
    clr     = 1'b0;
    en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req != '0) begin
          state_d    = RUN;
          gnt_d[win] = 1'b1;
          clr        = 1'b1;
          len_d      = win ? len1 : len0;
        end
      end
      RUN: begin
        // Abort takes precedence over completion on the final count.
        if (!req[owner]) begin
          state_d = IDLE;
          ptr_d   = ~owner;
        end else if (count == len_lat) begin
          state_d       = DONE;
          done_d[owner] = 1'b1;
          ptr_d         = ~owner;
        end else begin
          gnt_d[owner] = 1'b1;
          en           = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      len_lat <= '0;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      len_lat <= len_d;
      gnt     <= gnt_d;
      done    <= done_d;
      busy    <= (state_d == RUN);
    end
  end

  load_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .en   (en),
    .count(count)
  );

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter: vector table, corner sequences, random vs model.
`timescale 1ns/1ps
module tb_counter_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [3:0] len0, len1;
  logic [1:0] gnt;
  logic       busy;
  logic [3:0] count;
  logic [1:0] done;

  int checks = 0;
  int errors = 0;

  counter_arbiter #(.WIDTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .len0 (len0),
    .len1 (len1),
    .gnt  (gnt),
    .busy (busy),
    .count(count),
    .done (done)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0] req;
    logic [3:0] l0;
    logic [3:0] l1;
    logic [1:0] gnt;
    logic       busy;
    logic [3:0] cnt;
    logic [1:0] done;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic [1:0] g, input logic b,
                            input logic [3:0] c, input logic [1:0] d);
    chk({name, "_gnt"}, 32'(gnt), 32'(g));
    chk({name, "_busy"}, 32'(busy), 32'(b));
    chk({name, "_count"}, 32'(count), 32'(c));
    chk({name, "_done"}, 32'(done), 32'(d));
  endtask

  task automatic tick(input logic [1:0] r, input logic [3:0] a, input logic [3:0] b);
    req  = r;
    len0 = a;
    len1 = b;
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: who is served, cycles elapsed, latched length.
  int         m_owner, m_el, m_lat, m_last;
  bit         m_cool;
  logic [1:0] m_done;

  task automatic model_reset();
    m_owner = -1;
    m_el    = 0;
    m_lat   = 0;
    m_last  = 1;
    m_cool  = 0;
    m_done  = 2'b00;
  endtask

  task automatic model_step(input logic [1:0] r, input logic [3:0] a, input logic [3:0] b);
    m_done = 2'b00;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (m_el == m_lat) begin
        m_done[m_owner] = 1'b1;
        m_last  = m_owner;
        m_owner = -1;
        m_cool  = 1;
      end else begin
        m_el++;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (r != 2'b00) begin
      if (r == 2'b11) m_owner = (m_last == 0) ? 1 : 0;
      else            m_owner = r[1] ? 1 : 0;
      m_el  = 0;
      m_lat = (m_owner == 1) ? int'(b) : int'(a);
    end
  endtask

  initial begin
    logic [1:0] rr;
    logic [3:0] ra, rb;
    logic [1:0] eg;

    // Reset held 12 ns with both requesting: outputs stay quiet throughout.
    reset = 1'b0;
    req   = 2'b11;
    len0  = 4'd2;
    len1  = 4'd1;
    #1;  expect_out("rst_t1", 2'b00, 1'b0, 4'd0, 2'b00);
    #5;  expect_out("rst_t6", 2'b00, 1'b0, 4'd0, 2'b00);
    #5;  expect_out("rst_t11", 2'b00, 1'b0, 4'd0, 2'b00);
    #1;  reset = 1'b1;

    // Contention (0 then 1 then 0, abort), then a single len0=3 request.
    vecs[0]  = '{2'b11, 4'd2, 4'd1, 2'b01, 1'b1, 4'd0, 2'b00};
    vecs[1]  = '{2'b11, 4'd2, 4'd1, 2'b01, 1'b1, 4'd1, 2'b00};
    vecs[2]  = '{2'b11, 4'd2, 4'd1, 2'b01, 1'b1, 4'd2, 2'b00};
    vecs[3]  = '{2'b11, 4'd2, 4'd1, 2'b00, 1'b0, 4'd2, 2'b01};
    vecs[4]  = '{2'b11, 4'd2, 4'd1, 2'b00, 1'b0, 4'd2, 2'b00};
    vecs[5]  = '{2'b11, 4'd2, 4'd1, 2'b10, 1'b1, 4'd0, 2'b00};
    vecs[6]  = '{2'b11, 4'd2, 4'd1, 2'b10, 1'b1, 4'd1, 2'b00};
    vecs[7]  = '{2'b11, 4'd2, 4'd1, 2'b00, 1'b0, 4'd1, 2'b10};
    vecs[8]  = '{2'b11, 4'd2, 4'd1, 2'b00, 1'b0, 4'd1, 2'b00};
    vecs[9]  = '{2'b11, 4'd2, 4'd1, 2'b01, 1'b1, 4'd0, 2'b00};
    vecs[10] = '{2'b00, 4'd2, 4'd1, 2'b00, 1'b0, 4'd0, 2'b00};
    vecs[11] = '{2'b01, 4'd3, 4'd0, 2'b01, 1'b1, 4'd0, 2'b00};
    vecs[12] = '{2'b01, 4'd3, 4'd0, 2'b01, 1'b1, 4'd1, 2'b00};
    vecs[13] = '{2'b01, 4'd3, 4'd0, 2'b01, 1'b1, 4'd2, 2'b00};
    vecs[14] = '{2'b01, 4'd3, 4'd0, 2'b01, 1'b1, 4'd3, 2'b00};
    vecs[15] = '{2'b01, 4'd3, 4'd0, 2'b00, 1'b0, 4'd3, 2'b01};
    vecs[16] = '{2'b00, 4'd3, 4'd0, 2'b00, 1'b0, 4'd3, 2'b00};
    for (int i = 0; i < 17; i++) begin
      tick(vecs[i].req, vecs[i].l0, vecs[i].l1);
      expect_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].busy, vecs[i].cnt, vecs[i].done);
    end

    // len0 = 0: a single RUN cycle at count 0.
    tick(2'b01, 4'd0, 4'd0); expect_out("len0_run", 2'b01, 1'b1, 4'd0, 2'b00);
    tick(2'b01, 4'd0, 4'd0); expect_out("len0_done", 2'b00, 1'b0, 4'd0, 2'b01);
    tick(2'b00, 4'd0, 4'd0); expect_out("len0_idle", 2'b00, 1'b0, 4'd0, 2'b00);

    // len0 = 15: full range, no wrap; len changes after grant are ignored.
    tick(2'b01, 4'd15, 4'd0); expect_out("max_c0", 2'b01, 1'b1, 4'd0, 2'b00);
    for (int k = 1; k <= 15; k++) begin
      tick(2'b01, 4'd1, 4'd1);
      expect_out($sformatf("max_c%0d", k), 2'b01, 1'b1, 4'(k), 2'b00);
    end
    tick(2'b01, 4'd1, 4'd1); expect_out("max_done", 2'b00, 1'b0, 4'd15, 2'b01);
    tick(2'b00, 4'd1, 4'd1); expect_out("max_idle", 2'b00, 1'b0, 4'd15, 2'b00);

    // Abort at count 4: back to idle, count holds, no done pulse.
    tick(2'b01, 4'd10, 4'd0); expect_out("abt_c0", 2'b01, 1'b1, 4'd0, 2'b00);
    for (int k = 1; k <= 4; k++) begin
      tick(2'b01, 4'd10, 4'd0);
      expect_out($sformatf("abt_c%0d", k), 2'b01, 1'b1, 4'(k), 2'b00);
    end
    tick(2'b00, 4'd10, 4'd0); expect_out("abt_idle", 2'b00, 1'b0, 4'd4, 2'b00);
    tick(2'b00, 4'd10, 4'd0); expect_out("abt_hold", 2'b00, 1'b0, 4'd4, 2'b00);

    // Asynchronous reset at count 5, between clock edges.
    tick(2'b01, 4'd10, 4'd0); expect_out("ar_c0", 2'b01, 1'b1, 4'd0, 2'b00);
    for (int k = 1; k <= 5; k++) begin
      tick(2'b01, 4'd10, 4'd0);
      expect_out($sformatf("ar_c%0d", k), 2'b01, 1'b1, 4'(k), 2'b00);
    end
    #2 reset = 1'b0;
    #1 expect_out("ar_async", 2'b00, 1'b0, 4'd0, 2'b00);
    @(posedge clk); #1;
    expect_out("ar_held", 2'b00, 1'b0, 4'd0, 2'b00);
    req = 2'b00;
    #2 reset = 1'b1;
    tick(2'b00, 4'd0, 4'd0); expect_out("ar_after", 2'b00, 1'b0, 4'd0, 2'b00);

    // Random traffic against the reference model (DUT is idle, pointer at 0).
    model_reset();
    rr = 2'b00;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) rr[0] = ~rr[0];
      if ($urandom_range(0, 7) == 0) rr[1] = ~rr[1];
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      tick(rr, ra, rb);
      model_step(rr, ra, rb);
      eg = 2'b00;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      expect_out($sformatf("rnd%0d", n), eg, (m_owner >= 0), 4'(m_el), m_done);
      chk($sformatf("rnd%0d_onehot", n), 32'($onehot0(gnt)), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
